div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sequences the multi-cycle DIV/DIVU unit for the EX stage.
- Takes operands from the EX-stage instruction and feeds them to two AXI-stream divider cores, one signed and one unsigned, using their dividend/divisor/dout channels.
- Stalls EX until the quotient and remainder return, then holds the result for the HI/LO write.
- Handles flushes by draining in-flight divisions so that stale results never reach HI/LO.

Parameters:
- DATA_W, 32, operand width. The quotient and the remainder are each DATA_W bits.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset. The divider cores share this reset.
- es_valid  in  1  EX stage holds a valid instruction
- es_div  in  1  EX instruction is DIV (signed)
- es_divu  in  1  EX instruction is DIVU (unsigned)
- es_src1  in  DATA_W  dividend (rs value)
- es_src2  in  DATA_W  divisor (rt value)
- es_go  in  1  EX instruction leaves EX this cycle (es_to_ms_valid && ms_allowin)
- es_flush  in  1  cancel the EX instruction
- div_stall  out  1  EX must hold ready_go low
- div_done  out  1  result valid; stays high while in DONE
- div_quot  out  DATA_W  quotient (to LO)
- div_rem  out  DATA_W  remainder (to HI)
- div_dividend  out  DATA_W  dividend tdata, shared by both cores
- div_divisor  out  DATA_W  divisor tdata, shared by both cores
- sdiv_dividend_tvalid, sdiv_divisor_tvalid  out  1 each  signed core input valids
- sdiv_dividend_tready, sdiv_divisor_tready  in  1 each
- udiv_dividend_tvalid, udiv_divisor_tvalid  out  1 each  unsigned core input valids
- udiv_dividend_tready, udiv_divisor_tready  in  1 each
- sdiv_dout_tvalid  in  1 ; sdiv_dout_tdata  in  2*DATA_W  {quot, rem}
- udiv_dout_tvalid  in  1 ; udiv_dout_tdata  in  2*DATA_W  {quot, rem}

Behaviour:
- States are IDLE, SEND, WAIT, DONE and DRAIN. Internal registers:
  - sgn_r: the operation is signed
  - dvd_acc, dvs_acc: the dividend/divisor has been accepted
  - cancel_r: the operation was flushed
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE and all registers clear.
  - Every tvalid, div_done and div_stall are 0. div_quot/div_rem/div_dividend/div_divisor are 0.
  - Applies mid-operation too. The cores reset in the same cycle, so nothing is left to drain.
- start = es_valid & (es_div|es_divu) & ~es_flush.
- IDLE:
  - div_stall = start, combinational.
  - On start: latch the operands into div_dividend/div_divisor, set sgn_r=es_div, and go to SEND.
- SEND:
  - tvalid is high for the selected core only, on each channel not yet accepted.
  - A channel handshakes on tvalid & tready; its acc flag sets and its tvalid drops the next cycle.
  - The channels accept independently, in any order, possibly in the same cycle.
  - When both are accepted, go to WAIT (or to DRAIN if cancel_r is set).
  - tvalid is never withdrawn before its handshake (AXI-stream rule). A flush here sets cancel_r and does not abort.
  - div_stall = 1.
- WAIT:
  - div_stall = 1.
  - On the selected core's dout_tvalid, capture tdata[2*DATA_W-1:DATA_W] into div_quot and tdata[DATA_W-1:0] into div_rem, then go to DONE.
  - If es_flush arrives in the same cycle as dout_tvalid, discard the result and go to IDLE.
  - If es_flush arrives without dout_tvalid, go to DRAIN.
  - The dout channel has no tready; the core's tready is tied high.
- DONE:
  - div_done=1, div_stall=0, and the result is held.
  - Stay while es_go=0, so EX is free to stall for MEM backpressure without re-issuing.
  - es_go or es_flush sends the block to IDLE. The next div can start no earlier than the following cycle.
- DRAIN:
  - Wait for the selected core's dout_tvalid, discard it, then go to IDLE.
  - div_stall = start here, so a new div waits while non-div instructions pass.
  - div_done is 0.
- Latency: issue to div_done = (core latency) + 1 cycle for capture + the input handshake cycles.
- div_stall never depends on es_go, which avoids a combinational loop.
- Divide-by-zero: the core's result passes through unchanged (architecturally UNPREDICTABLE), and the block still terminates normally.
- A dout_tvalid from the unselected core is ignored. A dout_tvalid in IDLE or DONE is ignored.
- At most one division is in flight at any time.

Test Plan:
- DIVU with src1=100, src2=7, both treadys high, core latency 10 → div_stall high for 12 cycles, then div_done with quot=14, rem=2. Only the udiv tvalids ever assert, each for exactly 1 cycle.
- DIV with src1=0xFFFFFFF9 (-7), src2=2, divisor tready delayed 3 cycles after dividend → quot=0xFFFFFFFD, rem=0xFFFFFFFF. sdiv_divisor_tvalid is held for 4 cycles and dividend tvalid for 1.
- DONE with es_go held low for 5 cycles → div_done and the result are stable and no new tvalid is issued. es_go=1 → IDLE the next cycle.
- es_flush in WAIT cycle 3, then a DIV follows immediately → DRAIN discards the old dout and div_stall stays high. The new op's result is 0x00000003/0x00000001 for 10/3 and is not the stale value.
- es_flush during SEND with dividend not yet accepted → tvalid stays high until tready, then DRAIN, then IDLE. div_done never asserts.
- resetn=0 during WAIT → next cycle all outputs are 0 and the state is IDLE. After release, a DIVU of 9/4 gives quot=2, rem=1.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/stall sequencer for the DIV/DIVU AXI-stream divider cores.
// Feeds operands, stalls EX until {quot, rem} returns, drains flushed work.
module div_issue_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                es_valid,
  input  logic                es_div,
  input  logic                es_divu,
  input  logic [DATA_W-1:0]   es_src1,
  input  logic [DATA_W-1:0]   es_src2,
  input  logic                es_go,
  input  logic                es_flush,
  output logic                div_stall,
  output logic                div_done,
  output logic [DATA_W-1:0]   div_quot,
  output logic [DATA_W-1:0]   div_rem,
  output logic [DATA_W-1:0]   div_dividend,
  output logic [DATA_W-1:0]   div_divisor,
  output logic                sdiv_dividend_tvalid,
  output logic                sdiv_divisor_tvalid,
  input  logic                sdiv_dividend_tready,
  input  logic                sdiv_divisor_tready,
  output logic                udiv_dividend_tvalid,
  output logic                udiv_divisor_tvalid,
  input  logic                udiv_dividend_tready,
  input  logic                udiv_divisor_tready,
  input  logic                sdiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] sdiv_dout_tdata,
  input  logic                udiv_dout_tvalid,
  input  logic [2*DATA_W-1:0] udiv_dout_tdata
);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t              r_state;
  logic                r_sgn;
  logic                r_dvd_acc;
  logic                r_dvs_acc;
  logic                r_cancel;
  logic                r_done;
  logic                r_dvd_tv;
  logic                r_dvs_tv;
  logic [DATA_W-1:0]   r_dividend;
  logic [DATA_W-1:0]   r_divisor;
  logic [DATA_W-1:0]   r_quot;
  logic [DATA_W-1:0]   r_rem;

  logic                w_start;
  logic                w_dvd_rdy;
  logic                w_dvs_rdy;
  logic                w_dvd_hs;
  logic                w_dvs_hs;
  logic                w_dvd_ok;
  logic                w_dvs_ok;
  logic                w_dout_v;
  logic [2*DATA_W-1:0] w_dout;
  logic                w_stall;

  assign w_start   = es_valid & (es_div | es_divu) & ~es_flush;
  assign w_dvd_rdy = r_sgn ? sdiv_dividend_tready : udiv_dividend_tready;
  assign w_dvs_rdy = r_sgn ? sdiv_divisor_tready  : udiv_divisor_tready;
  assign w_dvd_hs  = r_dvd_tv & w_dvd_rdy;
  assign w_dvs_hs  = r_dvs_tv & w_dvs_rdy;
  assign w_dvd_ok  = r_dvd_acc | w_dvd_hs;
  assign w_dvs_ok  = r_dvs_acc | w_dvs_hs;
  assign w_dout_v  = r_sgn ? sdiv_dout_tvalid : udiv_dout_tvalid;
  assign w_dout    = r_sgn ? sdiv_dout_tdata  : udiv_dout_tdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_sgn      <= 1'b0;
      r_dvd_acc  <= 1'b0;
      r_dvs_acc  <= 1'b0;
      r_cancel   <= 1'b0;
      r_done     <= 1'b0;
      r_dvd_tv   <= 1'b0;
      r_dvs_tv   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dividend <= es_src1;
            r_divisor  <= es_src2;
            r_sgn      <= es_div;
            r_dvd_tv   <= 1'b1;
            r_dvs_tv   <= 1'b1;
            r_dvd_acc  <= 1'b0;
            r_dvs_acc  <= 1'b0;
            r_cancel   <= 1'b0;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // A flush cannot retract a pending tvalid; remember it and drain later.
          if (es_flush) r_cancel <= 1'b1;
          if (w_dvd_hs) begin
            r_dvd_acc <= 1'b1;
            r_dvd_tv  <= 1'b0;
          end
          if (w_dvs_hs) begin
            r_dvs_acc <= 1'b1;
            r_dvs_tv  <= 1'b0;
          end
          if (w_dvd_ok && w_dvs_ok)
            r_state <= (r_cancel || es_flush) ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (w_dout_v) begin
            if (es_flush) begin
              r_state <= S_IDLE;
            end else begin
              r_quot  <= w_dout[2*DATA_W-1:DATA_W];
              r_rem   <= w_dout[DATA_W-1:0];
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (es_flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (es_go || es_flush) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_dout_v) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is decoded from state and start only, never from es_go.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE, S_DRAIN: w_stall = w_start;
      S_SEND, S_WAIT:  w_stall = 1'b1;
      default:         w_stall = 1'b0;
    endcase
  end

  assign div_stall            = w_stall;
  assign div_done             = r_done;
  assign div_quot             = r_quot;
  assign div_rem              = r_rem;
  assign div_dividend         = r_dividend;
  assign div_divisor          = r_divisor;
  assign sdiv_dividend_tvalid = r_dvd_tv & r_sgn;
  assign sdiv_divisor_tvalid  = r_dvs_tv & r_sgn;
  assign udiv_dividend_tvalid = r_dvd_tv & ~r_sgn;
  assign udiv_divisor_tvalid  = r_dvs_tv & ~r_sgn;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with behavioural 10-cycle divider cores.
module tb_div_issue_ctrl;
  localparam int DATA_W = 32;
  localparam int LAT    = 10;

  logic clk = 1'b0;
  logic resetn;
  logic es_valid, es_div, es_divu, es_go, es_flush;
  logic [DATA_W-1:0] es_src1, es_src2;
  logic div_stall, div_done;
  logic [DATA_W-1:0] div_quot, div_rem, div_dividend, div_divisor;
  logic sdiv_dividend_tvalid, sdiv_divisor_tvalid, sdiv_dividend_tready, sdiv_divisor_tready;
  logic udiv_dividend_tvalid, udiv_divisor_tvalid, udiv_dividend_tready, udiv_divisor_tready;
  logic sdiv_dout_tvalid, udiv_dout_tvalid;
  logic [2*DATA_W-1:0] sdiv_dout_tdata, udiv_dout_tdata;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .es_valid(es_valid), .es_div(es_div), .es_divu(es_divu),
    .es_src1(es_src1), .es_src2(es_src2), .es_go(es_go), .es_flush(es_flush),
    .div_stall(div_stall), .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .sdiv_dividend_tvalid(sdiv_dividend_tvalid), .sdiv_divisor_tvalid(sdiv_divisor_tvalid),
    .sdiv_dividend_tready(sdiv_dividend_tready), .sdiv_divisor_tready(sdiv_divisor_tready),
    .udiv_dividend_tvalid(udiv_dividend_tvalid), .udiv_divisor_tvalid(udiv_divisor_tvalid),
    .udiv_dividend_tready(udiv_dividend_tready), .udiv_divisor_tready(udiv_divisor_tready),
    .sdiv_dout_tvalid(sdiv_dout_tvalid), .sdiv_dout_tdata(sdiv_dout_tdata),
    .udiv_dout_tvalid(udiv_dout_tvalid), .udiv_dout_tdata(udiv_dout_tdata)
  );

  // Behavioural divider cores: result appears LAT cycles after both inputs are taken.
  function automatic logic [63:0] udiv_f(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return '1;
    return {a / b, a % b};
  endfunction

  function automatic logic [63:0] sdiv_f(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return '1;
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {q, r};
  endfunction

  logic [3:0]  u_cnt, s_cnt;
  logic        u_ga, u_gb, s_ga, s_gb;
  logic [31:0] u_a, u_b, s_a, s_b;
  logic        u_hsa, u_hsb, s_hsa, s_hsb;

  assign u_hsa = udiv_dividend_tvalid & udiv_dividend_tready;
  assign u_hsb = udiv_divisor_tvalid  & udiv_divisor_tready;
  assign s_hsa = sdiv_dividend_tvalid & sdiv_dividend_tready;
  assign s_hsb = sdiv_divisor_tvalid  & sdiv_divisor_tready;

  always @(posedge clk) begin
    if (!resetn) begin
      u_cnt <= '0; u_ga <= 1'b0; u_gb <= 1'b0; u_a <= '0; u_b <= '0;
      udiv_dout_tvalid <= 1'b0; udiv_dout_tdata <= '0;
    end else begin
      udiv_dout_tvalid <= 1'b0;
      if (u_cnt != 0) begin
        u_cnt <= u_cnt - 4'd1;
        if (u_cnt == 4'd1) begin
          udiv_dout_tvalid <= 1'b1;
          udiv_dout_tdata  <= udiv_f(u_a, u_b);
        end
      end else if ((u_ga | u_hsa) & (u_gb | u_hsb)) begin
        u_cnt <= 4'(LAT - 1); u_ga <= 1'b0; u_gb <= 1'b0;
        u_a <= div_dividend; u_b <= div_divisor;
      end else begin
        if (u_hsa) u_ga <= 1'b1;
        if (u_hsb) u_gb <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      s_cnt <= '0; s_ga <= 1'b0; s_gb <= 1'b0; s_a <= '0; s_b <= '0;
      sdiv_dout_tvalid <= 1'b0; sdiv_dout_tdata <= '0;
    end else begin
      sdiv_dout_tvalid <= 1'b0;
      if (s_cnt != 0) begin
        s_cnt <= s_cnt - 4'd1;
        if (s_cnt == 4'd1) begin
          sdiv_dout_tvalid <= 1'b1;
          sdiv_dout_tdata  <= sdiv_f(s_a, s_b);
        end
      end else if ((s_ga | s_hsa) & (s_gb | s_hsb)) begin
        s_cnt <= 4'(LAT - 1); s_ga <= 1'b0; s_gb <= 1'b0;
        s_a <= div_dividend; s_b <= div_divisor;
      end else begin
        if (s_hsa) s_ga <= 1'b1;
        if (s_hsb) s_gb <= 1'b1;
      end
    end
  end

  // Per-cycle activity counters, sampled at the edge that closes each cycle.
  int unsigned n_stall = 0, n_nostall = 0, n_done = 0;
  int unsigned n_sdvd = 0, n_sdvs = 0, n_udvd = 0, n_udvs = 0;
  always @(posedge clk) begin
    n_stall   <= n_stall + 32'(div_stall);
    n_nostall <= n_nostall + 32'(!div_stall);
    n_done    <= n_done + 32'(div_done);
    n_sdvd    <= n_sdvd + 32'(sdiv_dividend_tvalid);
    n_sdvs    <= n_sdvs + 32'(sdiv_divisor_tvalid);
    n_udvd    <= n_udvd + 32'(udiv_dividend_tvalid);
    n_udvs    <= n_udvs + 32'(udiv_divisor_tvalid);
  end

  int unsigned n_pass = 0, n_total = 0;
  int unsigned b_stall, b_nostall, b_done, b_sdvd, b_sdvs, b_udvd, b_udvs;
  logic [5:0] w_flags;
  assign w_flags = {div_stall, div_done, sdiv_dividend_tvalid, sdiv_divisor_tvalid,
                    udiv_dividend_tvalid, udiv_divisor_tvalid};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic snap;
    b_stall = n_stall; b_nostall = n_nostall; b_done = n_done;
    b_sdvd = n_sdvd; b_sdvs = n_sdvs; b_udvd = n_udvd; b_udvs = n_udvs;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    while (div_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(n < 200), 64'd1);
    #1;
  endtask

  task automatic go_idle(input string tag);
    es_go = 1'b1;
    @(posedge clk);
    #1;
    es_go = 1'b0; es_valid = 1'b0; es_div = 1'b0; es_divu = 1'b0;
    #1;
    chk(tag, {div_stall, div_done}, 2'b00);
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    es_valid = 1'b1; es_div = sgn; es_divu = ~sgn; es_src1 = a; es_src2 = b;
  endtask

  initial begin
    resetn = 1'b0; es_valid = 1'b0; es_div = 1'b0; es_divu = 1'b0;
    es_go = 1'b0; es_flush = 1'b0; es_src1 = '0; es_src2 = '0;
    sdiv_dividend_tready = 1'b1; sdiv_divisor_tready = 1'b1;
    udiv_dividend_tready = 1'b1; udiv_divisor_tready = 1'b1;
    cyc; cyc;
    chk("rst_flags", 64'(w_flags), 64'd0);
    chk("rst_result", {div_quot, div_rem}, 64'd0);
    chk("rst_operands", {div_dividend, div_divisor}, 64'd0);
    resetn = 1'b1;

    // DIVU 100/7, both treadys high
    cyc;
    issue(1'b0, 32'd100, 32'd7);
    snap;
    #1 chk("divu_stall_idle", 64'(div_stall), 64'd1);
    wait_done("divu_timeout");
    chk("divu_stall_cycles", 64'(n_stall - b_stall), 64'd12);
    chk("divu_result", {div_quot, div_rem}, {32'd14, 32'd2});
    chk("divu_tv_cycles", {32'(n_udvd - b_udvd), 32'(n_udvs - b_udvs)}, {32'd1, 32'd1});
    chk("divu_sdiv_tv", 64'(n_sdvd - b_sdvd + n_sdvs - b_sdvs), 64'd0);
    go_idle("divu_idle");

    // DIV -7/2 with divisor tready late by 3 cycles, then DONE held
    cyc;
    sdiv_divisor_tready = 1'b0;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    snap;
    cyc; cyc; cyc; cyc;
    sdiv_divisor_tready = 1'b1;
    wait_done("div_timeout");
    chk("div_result", {div_quot, div_rem}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    chk("div_tv_cycles", {32'(n_sdvd - b_sdvd), 32'(n_sdvs - b_sdvs)}, {32'd1, 32'd4});
    chk("div_udiv_tv", 64'(n_udvd - b_udvd + n_udvs - b_udvs), 64'd0);
    snap;
    for (int i = 0; i < 5; i++) begin
      cyc;
      chk("hold_state", {30'(0), div_stall, div_done, div_quot}, {30'(0), 1'b0, 1'b1, 32'hFFFF_FFFD});
    end
    chk("hold_no_tv", 64'(n_sdvd - b_sdvd + n_sdvs - b_sdvs + n_udvd - b_udvd + n_udvs - b_udvs), 64'd0);
    go_idle("hold_idle");

    // flush in the third WAIT cycle, next DIV 10/3 follows at once
    cyc;
    issue(1'b1, 32'd50, 32'd5);
    cyc; cyc; cyc; cyc;
    es_flush = 1'b1;
    #1 chk("wflush_stall", 64'(div_stall), 64'd1);
    cyc;
    es_flush = 1'b0;
    issue(1'b1, 32'd10, 32'd3);
    snap;
    #1 chk("drain_stall", 64'(div_stall), 64'd1);
    wait_done("wflush_timeout");
    chk("drain_no_gap", {32'(n_nostall - b_nostall), 32'(n_done - b_done)}, 64'd0);
    chk("wflush_result", {div_quot, div_rem}, {32'd3, 32'd1});
    go_idle("wflush_idle");

    // flush during SEND with dividend still pending
    cyc;
    udiv_dividend_tready = 1'b0;
    issue(1'b0, 32'd40, 32'd3);
    snap;
    cyc;
    es_flush = 1'b1;
    #1 chk("sflush_c1", {div_stall, udiv_dividend_tvalid}, 2'b11);
    cyc;
    es_flush = 1'b0; es_valid = 1'b0; es_divu = 1'b0;
    #1 chk("sflush_c2_tv", 64'(udiv_dividend_tvalid), 64'd1);
    cyc;
    udiv_dividend_tready = 1'b1;
    #1 chk("sflush_c3_tv", 64'(udiv_dividend_tvalid), 64'd1);
    cyc;
    chk("sflush_drain", 64'(w_flags), 64'd0);
    cyc; cyc;
    issue(1'b0, 32'd20, 32'd6);
    #1 chk("sflush_new_stall", 64'(div_stall), 64'd1);
    repeat (7) cyc;
    chk("sflush_c13_tv", 64'(udiv_dividend_tvalid), 64'd0);
    cyc;
    chk("sflush_c14_tv", 64'(udiv_dividend_tvalid), 64'd0);
    cyc;
    chk("sflush_c15_tv", 64'(udiv_dividend_tvalid), 64'd1);
    wait_done("sflush_timeout");
    chk("sflush_no_done", 64'(n_done - b_done), 64'd0);
    chk("sflush_result", {div_quot, div_rem}, {32'd3, 32'd2});
    go_idle("sflush_idle");

    // reset during WAIT, then DIVU 9/4
    cyc;
    issue(1'b0, 32'd77, 32'd3);
    cyc; cyc; cyc;
    resetn = 1'b0; es_valid = 1'b0; es_divu = 1'b0;
    cyc;
    chk("mrst_flags", 64'(w_flags), 64'd0);
    chk("mrst_result", {div_quot, div_rem}, 64'd0);
    chk("mrst_operands", {div_dividend, div_divisor}, 64'd0);
    resetn = 1'b1;
    cyc;
    issue(1'b0, 32'd9, 32'd4);
    wait_done("mrst_timeout");
    chk("mrst_divu_result", {div_quot, div_rem}, {32'd2, 32'd1});
    go_idle("mrst_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
